// File: rtl/l2_cache_nway.sv
// l2_cache_nway
//   N-way set-associative, write-back, write-allocate L2 cache controller.
//   Lines move as whole LINE_W words between the L1 side and the memory side.
//   Misses pick the lowest invalid way; when the set is full they take the
//   set's round-robin pointer. A write miss installs the L1 line directly,
//   without fetching from memory.
//
// Optional feature (macro L2_DIRTY_FLUSH_EN):
//   defined   - flush walks every set/way, writes back dirty lines, then
//               invalidates them.
//   undefined - flush drops all lines (dirty data discarded) in one cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   tag_L1_L2, index_L1_L2        request address from L1
//   write_data                    full-line write data from L1
//   read_L1_L2, write_L1_L2       level requests, held until ready_L2_L1
//   flush                         one-cycle flush pulse (accepted in IDLE)
//   ready_L2_L1, read_data_L2_L1  completion strobe and read line to L1
//   read_L2_MEM, tag/index_L2_MEM line fetch request to memory
//   write_L2_MEM, write_*_L2_MEM  write-back request to memory
//   read_data_MEM_L2, ready_MEM_L2 memory data and completion strobe
//   flush_busy                    high while a flush is running
module l2_cache_nway #(
    parameter int TNUM   = 18,
    parameter int INUM   = 8,
    parameter int NWAY   = 4,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TNUM-1:0]   tag_L1_L2,
    input  logic [INUM-1:0]   index_L1_L2,
    input  logic [LINE_W-1:0] write_data,
    input  logic              read_L1_L2,
    input  logic              write_L1_L2,
    input  logic              flush,
    output logic              ready_L2_L1,
    output logic [LINE_W-1:0] read_data_L2_L1,
    output logic              read_L2_MEM,
    output logic [TNUM-1:0]   tag_L2_MEM,
    output logic [INUM-1:0]   index_L2_MEM,
    output logic              write_L2_MEM,
    output logic [TNUM-1:0]   write_tag_L2_MEM,
    output logic [INUM-1:0]   write_index_L2_MEM,
    output logic [LINE_W-1:0] write_data_L2_MEM,
    input  logic [LINE_W-1:0] read_data_MEM_L2,
    input  logic              ready_MEM_L2,
    output logic              flush_busy
);

    localparam int SETS = 1 << INUM;
    localparam int WAYW = $clog2(NWAY);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WB, S_FETCH, S_RESP, S_FLUSH
    } state_t;

    state_t state, next_state;

    logic [TNUM-1:0]   tag_mem   [SETS][NWAY];
    logic [LINE_W-1:0] data_mem  [SETS][NWAY];
    logic [NWAY-1:0]   valid_mem [SETS];
    logic [NWAY-1:0]   dirty_mem [SETS];
    logic [WAYW-1:0]   rr_ptr    [SETS];

    logic [TNUM-1:0]   req_tag;
    logic [INUM-1:0]   req_index;
    logic [LINE_W-1:0] req_data;
    logic              req_write;
    logic [WAYW-1:0]   victim_way;

    logic              hit, inv_found, victim_dirty;
    logic [WAYW-1:0]   hit_way, inv_way, victim;

    logic              line_we;
    logic [WAYW-1:0]   line_way;
    logic [LINE_W-1:0] line_wdata;

`ifdef L2_DIRTY_FLUSH_EN
    logic [INUM-1:0]   flush_set;
    logic [WAYW-1:0]   flush_way;
    logic              fl_dirty, fl_done, fl_last;

    // The walk finishes a line either immediately (clean/invalid) or when
    // memory acknowledges its write-back.
    always_comb begin
        fl_dirty = valid_mem[flush_set][flush_way] && dirty_mem[flush_set][flush_way];
        fl_done  = !fl_dirty || (write_L2_MEM && ready_MEM_L2);
        fl_last  = (&flush_set) && (&flush_way);
    end
`endif

    // Tag match over all ways of the requested set, plus victim choice:
    // lowest-numbered invalid way first, otherwise the round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (valid_mem[req_index][w] && (tag_mem[req_index][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
            if (!valid_mem[req_index][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYW'(w);
            end
        end
        victim       = inv_found ? inv_way : rr_ptr[req_index];
        victim_dirty = valid_mem[req_index][victim] && dirty_mem[req_index][victim];
    end

    // Next-state logic. IDLE ignores requests during the ready cycle so a
    // request still held by L1 is not taken twice.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (flush)
                    next_state = S_FLUSH;
                else if (!ready_L2_L1 && (read_L1_L2 || write_L1_L2))
                    next_state = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit)               next_state = S_IDLE;
                else if (victim_dirty) next_state = S_WB;
                else if (req_write)    next_state = S_RESP;
                else                   next_state = S_FETCH;
            end
            S_WB: begin
                if (ready_MEM_L2) next_state = req_write ? S_RESP : S_FETCH;
            end
            S_FETCH: begin
                if (ready_MEM_L2) next_state = S_RESP;
            end
            S_RESP:  next_state = S_IDLE;
            S_FLUSH: begin
`ifdef L2_DIRTY_FLUSH_EN
                if (fl_done && fl_last) next_state = S_IDLE;
`else
                next_state = S_IDLE;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Line/tag write port: write hit, fetch install, or write-miss install.
    always_comb begin
        line_we    = 1'b0;
        line_way   = victim_way;
        line_wdata = req_data;
        case (state)
            S_COMPARE: if (hit && req_write) begin
                line_we  = 1'b1;
                line_way = hit_way;
            end
            S_FETCH: if (ready_MEM_L2) begin
                line_we    = 1'b1;
                line_wdata = read_data_MEM_L2;
            end
            S_RESP: if (req_write) line_we = 1'b1;
            default: ;
        endcase
        if (rst) line_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Line storage carries no reset; validity lives in valid_mem.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[req_index][line_way] <= line_wdata;
            tag_mem[req_index][line_way]  <= req_tag;
        end
    end

    // Control/status state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                rr_ptr[s]    <= '0;
            end
            req_tag            <= '0;
            req_index          <= '0;
            req_data           <= '0;
            req_write          <= 1'b0;
            victim_way         <= '0;
            ready_L2_L1        <= 1'b0;
            read_data_L2_L1    <= '0;
            read_L2_MEM        <= 1'b0;
            tag_L2_MEM         <= '0;
            index_L2_MEM       <= '0;
            write_L2_MEM       <= 1'b0;
            write_tag_L2_MEM   <= '0;
            write_index_L2_MEM <= '0;
            write_data_L2_MEM  <= '0;
            flush_busy         <= 1'b0;
`ifdef L2_DIRTY_FLUSH_EN
            flush_set          <= '0;
            flush_way          <= '0;
`endif
        end else begin
            ready_L2_L1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        flush_busy <= 1'b1;
`ifdef L2_DIRTY_FLUSH_EN
                        flush_set  <= '0;
                        flush_way  <= '0;
`endif
                    end else if (!ready_L2_L1 && (read_L1_L2 || write_L1_L2)) begin
                        req_tag   <= tag_L1_L2;
                        req_index <= index_L1_L2;
                        req_data  <= write_data;
                        req_write <= write_L1_L2;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        ready_L2_L1 <= 1'b1;
                        if (req_write) dirty_mem[req_index][hit_way] <= 1'b1;
                        else           read_data_L2_L1 <= data_mem[req_index][hit_way];
                    end else begin
                        victim_way <= victim;
                        // Pointer moves only when a valid line is displaced.
                        if (!inv_found) rr_ptr[req_index] <= rr_ptr[req_index] + 1'b1;
                        if (victim_dirty) begin
                            write_L2_MEM       <= 1'b1;
                            write_tag_L2_MEM   <= tag_mem[req_index][victim];
                            write_index_L2_MEM <= req_index;
                            write_data_L2_MEM  <= data_mem[req_index][victim];
                        end else if (!req_write) begin
                            read_L2_MEM  <= 1'b1;
                            tag_L2_MEM   <= req_tag;
                            index_L2_MEM <= req_index;
                        end
                    end
                end
                S_WB: begin
                    if (ready_MEM_L2) begin
                        write_L2_MEM <= 1'b0;
                        if (!req_write) begin
                            read_L2_MEM  <= 1'b1;
                            tag_L2_MEM   <= req_tag;
                            index_L2_MEM <= req_index;
                        end
                    end
                end
                S_FETCH: begin
                    if (ready_MEM_L2) begin
                        read_L2_MEM                       <= 1'b0;
                        valid_mem[req_index][victim_way]  <= 1'b1;
                        dirty_mem[req_index][victim_way]  <= 1'b0;
                    end
                end
                S_RESP: begin
                    ready_L2_L1 <= 1'b1;
                    if (req_write) begin
                        valid_mem[req_index][victim_way] <= 1'b1;
                        dirty_mem[req_index][victim_way] <= 1'b1;
                    end else begin
                        read_data_L2_L1 <= data_mem[req_index][victim_way];
                    end
                end
                S_FLUSH: begin
`ifdef L2_DIRTY_FLUSH_EN
                    if (fl_dirty && !write_L2_MEM) begin
                        write_L2_MEM       <= 1'b1;
                        write_tag_L2_MEM   <= tag_mem[flush_set][flush_way];
                        write_index_L2_MEM <= flush_set;
                        write_data_L2_MEM  <= data_mem[flush_set][flush_way];
                    end else if (fl_done) begin
                        write_L2_MEM                    <= 1'b0;
                        valid_mem[flush_set][flush_way] <= 1'b0;
                        dirty_mem[flush_set][flush_way] <= 1'b0;
                        rr_ptr[flush_set]               <= '0;
                        flush_way                       <= flush_way + 1'b1;
                        if (&flush_way) flush_set <= flush_set + 1'b1;
                        if (fl_last)    flush_busy <= 1'b0;
                    end
`else
                    for (int s = 0; s < SETS; s++) begin
                        valid_mem[s] <= '0;
                        dirty_mem[s] <= '0;
                        rr_ptr[s]    <= '0;
                    end
                    flush_busy <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Self-checking bench for l2_cache_nway: directed requests push expected
// L1 responses and memory requests into queues; a monitor pops and compares
// whenever the DUT presents ready_L2_L1 or raises a memory request.
module tb_l2_cache_nway;

    localparam int TNUM   = 18;
    localparam int INUM   = 8;
    localparam int NWAY   = 4;
    localparam int LINE_W = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [TNUM-1:0]   tag_L1_L2;
    logic [INUM-1:0]   index_L1_L2;
    logic [LINE_W-1:0] write_data;
    logic              read_L1_L2, write_L1_L2, flush;
    logic              ready_L2_L1;
    logic [LINE_W-1:0] read_data_L2_L1;
    logic              read_L2_MEM, write_L2_MEM;
    logic [TNUM-1:0]   tag_L2_MEM, write_tag_L2_MEM;
    logic [INUM-1:0]   index_L2_MEM, write_index_L2_MEM;
    logic [LINE_W-1:0] write_data_L2_MEM;
    logic [LINE_W-1:0] read_data_MEM_L2;
    logic              ready_MEM_L2;
    logic              flush_busy;

    l2_cache_nway #(.TNUM(TNUM), .INUM(INUM), .NWAY(NWAY), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2), .write_data(write_data),
        .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .flush(flush),
        .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1),
        .read_L2_MEM(read_L2_MEM), .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
        .write_L2_MEM(write_L2_MEM), .write_tag_L2_MEM(write_tag_L2_MEM),
        .write_index_L2_MEM(write_index_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
        .read_data_MEM_L2(read_data_MEM_L2), .ready_MEM_L2(ready_MEM_L2),
        .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_read;
        logic [LINE_W-1:0] data;
    } l1_exp_t;

    typedef struct {
        logic              is_write;
        logic [TNUM-1:0]   tag;
        logic [INUM-1:0]   index;
        logic [LINE_W-1:0] data;
    } mem_exp_t;

    l1_exp_t  l1_q[$];
    mem_exp_t mem_q[$];

    int total = 0;
    int bad   = 0;

    logic [LINE_W-1:0] mem_fill;
    logic              mem_auto;
    int                mem_wait;
    logic              prev_rd = 1'b0;
    logic              prev_wr = 1'b0;

    function automatic logic [LINE_W-1:0] pat(input logic [7:0] b);
        return {(LINE_W/8){b}};
    endfunction

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expectL1Read(input logic [LINE_W-1:0] d);
        l1_exp_t e;
        e.is_read = 1'b1;
        e.data    = d;
        l1_q.push_back(e);
    endtask

    task automatic expectL1Write();
        l1_exp_t e;
        e.is_read = 1'b0;
        e.data    = '0;
        l1_q.push_back(e);
    endtask

    task automatic expectMem(input logic is_wr, input logic [TNUM-1:0] t,
                             input logic [INUM-1:0] i, input logic [LINE_W-1:0] d);
        mem_exp_t e;
        e.is_write = is_wr;
        e.tag      = t;
        e.index    = i;
        e.data     = d;
        mem_q.push_back(e);
    endtask

    // Issue one L1 request and hold it until ready; lat = cycles to ready.
    task automatic applyStimulus(input logic is_wr, input logic [TNUM-1:0] t,
                                 input logic [INUM-1:0] i, input logic [LINE_W-1:0] d,
                                 output int lat);
        @(negedge clk);
        tag_L1_L2   = t;
        index_L1_L2 = i;
        write_data  = d;
        if (is_wr) write_L1_L2 = 1'b1;
        else       read_L1_L2  = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (ready_L2_L1) break;
        end
        if (!ready_L2_L1) checkOutput("l1_ready_timeout", ready_L2_L1, 1);
        read_L1_L2  = 1'b0;
        write_L1_L2 = 1'b0;
    endtask

    // Memory model: acknowledge any pending request two cycles after it is seen.
    initial begin
        ready_MEM_L2     = 1'b0;
        read_data_MEM_L2 = '0;
        mem_wait         = 0;
        forever begin
            @(negedge clk);
            if (ready_MEM_L2) begin
                ready_MEM_L2 = 1'b0;
                mem_wait     = 0;
            end else if (mem_auto && (read_L2_MEM || write_L2_MEM)) begin
                mem_wait++;
                if (mem_wait >= 2) begin
                    ready_MEM_L2     = 1'b1;
                    read_data_MEM_L2 = mem_fill;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    // Monitor: compares every L1 response and every new memory request.
    initial begin
        l1_exp_t  le;
        mem_exp_t me;
        forever begin
            @(negedge clk);
            if (ready_L2_L1) begin
                checkOutput("l1_resp_expected", l1_q.size() != 0, 1);
                if (l1_q.size() != 0) begin
                    le = l1_q.pop_front();
                    if (le.is_read) checkOutput("read_data", read_data_L2_L1, le.data);
                    else            checkOutput("write_ack_mem_idle", {read_L2_MEM, write_L2_MEM}, 0);
                end
            end
            if (read_L2_MEM || write_L2_MEM)
                checkOutput("mem_rd_wr_exclusive", read_L2_MEM & write_L2_MEM, 0);
            if ((read_L2_MEM && !prev_rd) || (write_L2_MEM && !prev_wr)) begin
                checkOutput("mem_req_expected", mem_q.size() != 0, 1);
                if (mem_q.size() != 0) begin
                    me = mem_q.pop_front();
                    checkOutput("mem_kind", write_L2_MEM, me.is_write);
                    if (me.is_write) begin
                        checkOutput("wb_tag",   write_tag_L2_MEM,   me.tag);
                        checkOutput("wb_index", write_index_L2_MEM, me.index);
                        checkOutput("wb_data",  write_data_L2_MEM,  me.data);
                    end else begin
                        checkOutput("fetch_tag",   tag_L2_MEM,   me.tag);
                        checkOutput("fetch_index", index_L2_MEM, me.index);
                    end
                end
            end
            prev_rd = read_L2_MEM;
            prev_wr = write_L2_MEM;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int waited;
        rst = 1'b1; tag_L1_L2 = '0; index_L1_L2 = '0; write_data = '0;
        read_L1_L2 = 1'b0; write_L1_L2 = 1'b0; flush = 1'b0;
        mem_auto = 1'b1; mem_fill = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready",     ready_L2_L1, 0);
        checkOutput("rst_read_mem",  read_L2_MEM, 0);
        checkOutput("rst_write_mem", write_L2_MEM, 0);
        checkOutput("rst_flush_busy", flush_busy, 0);
        checkOutput("rst_read_data", read_data_L2_L1, 0);

        // Cold read miss
        mem_fill = pat(8'hAA);
        expectMem(1'b0, 18'h00001, 8'd5, '0);
        expectL1Read(pat(8'hAA));
        applyStimulus(1'b0, 18'h00001, 8'd5, '0, lat);

        // Hit latency
        expectL1Read(pat(8'hAA));
        applyStimulus(1'b0, 18'h00001, 8'd5, '0, lat);
        checkOutput("hit_latency", lat, 2);

        // Fill set 5 with tags 2..4, then replace round-robin
        for (int t = 2; t <= 4; t++) begin
            mem_fill = pat(8'(t));
            expectMem(1'b0, 18'(t), 8'd5, '0);
            expectL1Read(pat(8'(t)));
            applyStimulus(1'b0, 18'(t), 8'd5, '0, lat);
        end
        mem_fill = pat(8'hF0);
        expectMem(1'b0, 18'h3FFFF, 8'd5, '0);
        expectL1Read(pat(8'hF0));
        applyStimulus(1'b0, 18'h3FFFF, 8'd5, '0, lat);
        mem_fill = pat(8'h11);
        expectMem(1'b0, 18'h00001, 8'd5, '0);
        expectL1Read(pat(8'h11));
        applyStimulus(1'b0, 18'h00001, 8'd5, '0, lat);
        mem_fill = pat(8'h22);
        expectMem(1'b0, 18'h00002, 8'd5, '0);
        expectL1Read(pat(8'h22));
        applyStimulus(1'b0, 18'h00002, 8'd5, '0, lat);
        expectL1Read(pat(8'h04));
        applyStimulus(1'b0, 18'h00004, 8'd5, '0, lat);
        checkOutput("hit_latency_way3", lat, 2);
        expectL1Read(pat(8'hF0));
        applyStimulus(1'b0, 18'h3FFFF, 8'd5, '0, lat);
        checkOutput("hit_latency_way0", lat, 2);

        // Dirty write-back on miss
        expectL1Write();
        applyStimulus(1'b1, 18'h00002, 8'd9, pat(8'h55), lat);
        for (int t = 10; t <= 12; t++) begin
            mem_fill = pat(8'(8'hA0 + t));
            expectMem(1'b0, 18'(t), 8'd9, '0);
            expectL1Read(pat(8'(8'hA0 + t)));
            applyStimulus(1'b0, 18'(t), 8'd9, '0, lat);
        end
        mem_fill = pat(8'h66);
        expectMem(1'b1, 18'h00002, 8'd9, pat(8'h55));
        expectMem(1'b0, 18'h00003, 8'd9, '0);
        expectL1Read(pat(8'h66));
        applyStimulus(1'b0, 18'h00003, 8'd9, '0, lat);

        // Write miss on a clean set, then hit read and write hit
        expectL1Write();
        applyStimulus(1'b1, 18'h00007, 8'd20, pat(8'h5A), lat);
        expectL1Read(pat(8'h5A));
        applyStimulus(1'b0, 18'h00007, 8'd20, '0, lat);
        checkOutput("read_after_wmiss_latency", lat, 2);
        expectL1Write();
        applyStimulus(1'b1, 18'h00007, 8'd20, pat(8'h33), lat);
        checkOutput("write_hit_latency", lat, 2);
        expectL1Read(pat(8'h33));
        applyStimulus(1'b0, 18'h00007, 8'd20, '0, lat);

        // Reset clears all lines
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst2_ready", ready_L2_L1, 0);
        checkOutput("rst2_read_data", read_data_L2_L1, 0);
        mem_fill = pat(8'h99);
        expectMem(1'b0, 18'h00007, 8'd20, '0);
        expectL1Read(pat(8'h99));
        applyStimulus(1'b0, 18'h00007, 8'd20, '0, lat);

        // Flush with dirty lines at index 0 and 255
        expectL1Write();
        applyStimulus(1'b1, 18'h00100, 8'd0, pat(8'hC3), lat);
        expectL1Write();
        applyStimulus(1'b1, 18'h00200, 8'd255, pat(8'h3C), lat);
`ifdef L2_DIRTY_FLUSH_EN
        expectMem(1'b1, 18'h00100, 8'd0,   pat(8'hC3));
        expectMem(1'b1, 18'h00200, 8'd255, pat(8'h3C));
`endif
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy_start", flush_busy, 1);
        waited = 0;
        while (flush_busy && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("flush_busy_end", flush_busy, 0);
        checkOutput("flush_writebacks_drained", mem_q.size(), 0);
        mem_fill = pat(8'hD1);
        expectMem(1'b0, 18'h00100, 8'd0, '0);
        expectL1Read(pat(8'hD1));
        applyStimulus(1'b0, 18'h00100, 8'd0, '0, lat);
        mem_fill = pat(8'hD2);
        expectMem(1'b0, 18'h00200, 8'd255, '0);
        expectL1Read(pat(8'hD2));
        applyStimulus(1'b0, 18'h00200, 8'd255, '0, lat);

        // Reset in the middle of a write-back drops the request
        expectL1Write();
        applyStimulus(1'b1, 18'h00011, 8'd3, pat(8'h77), lat);
        for (int t = 18; t <= 20; t++) begin
            mem_fill = pat(8'(t));
            expectMem(1'b0, 18'(t), 8'd3, '0);
            expectL1Read(pat(8'(t)));
            applyStimulus(1'b0, 18'(t), 8'd3, '0, lat);
        end
        mem_auto = 1'b0;
        expectMem(1'b1, 18'h00011, 8'd3, pat(8'h77));
        @(negedge clk);
        tag_L1_L2   = 18'h00015;
        index_L1_L2 = 8'd3;
        read_L1_L2  = 1'b1;
        waited = 0;
        while (!write_L2_MEM && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wb_reached", write_L2_MEM, 1);
        rst        = 1'b1;
        read_L1_L2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_wb_write", write_L2_MEM, 0);
        checkOutput("rst_mid_wb_read",  read_L2_MEM, 0);
        mem_auto = 1'b1;

        repeat (5) @(negedge clk);
        checkOutput("l1_queue_left",  l1_q.size(), 0);
        checkOutput("mem_queue_left", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate L2 cache controller with full-line (LINE_W) transfers between the L1 and memory handshake interfaces.
- Successor to the fixed 4-way L2: way count, tag/index split and line width are parameters.
- Adds per-set round-robin victim selection and no-fetch write-miss allocation.
- Optionally adds a dirty-line write-back flush walk.

Parameters:
TNUM  18  tag bits
INUM  8  index bits; sets = 2**INUM
NWAY  4  ways per set; power of 2, >= 2
LINE_W  512  line width in bits

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
tag_L1_L2  in  TNUM  request tag
index_L1_L2  in  INUM  request index
write_data  in  LINE_W  full-line write data from L1
read_L1_L2  in  1  read request, level, held until ready_L2_L1
write_L1_L2  in  1  write request, level, held until ready_L2_L1
flush  in  1  flush request, 1-cycle pulse
ready_L2_L1  out  1  1-cycle completion strobe to L1
read_data_L2_L1  out  LINE_W  read line; valid while ready_L2_L1=1
read_L2_MEM  out  1  line fetch request
tag_L2_MEM  out  TNUM  fetch tag
index_L2_MEM  out  INUM  fetch index
write_L2_MEM  out  1  write-back request
write_tag_L2_MEM  out  TNUM  write-back tag
write_index_L2_MEM  out  INUM  write-back index
write_data_L2_MEM  out  LINE_W  write-back line
read_data_MEM_L2  in  LINE_W  fetched line; valid with ready_MEM_L2
ready_MEM_L2  in  1  memory completion strobe
flush_busy  out  1  high while a flush is in progress

Behaviour:
- Reset:
  - All valid/dirty bits and victim pointers cleared; FSM to IDLE.
  - All outputs 0; data outputs 0.
  - A reset mid-transaction drops any MEM request in the same cycle.
- States: IDLE, COMPARE, WB, FETCH, RESP, FLUSH.
- IDLE:
  - flush=1 has priority over requests: go to FLUSH.
  - Otherwise, if read or write is high, latch tag/index/write_data and go to COMPARE. write_L1_L2 wins if both are high.
- COMPARE: parallel tag match over NWAY ways.
  - Read hit: read_data_L2_L1 = line, ready_L2_L1=1 this cycle, go to IDLE. Hit latency is 2 cycles from request to ready.
  - Write hit: write line, set dirty, ready_L2_L1=1 this cycle, go to IDLE.
  - Miss, victim selection: lowest-numbered invalid way; if none, victim = set's round-robin pointer.
  - Miss: if the victim is valid and dirty, go to WB; else read miss goes to FETCH, write miss goes to RESP.
- WB:
  - write_L2_MEM=1 with the victim's tag, index and line, held until ready_MEM_L2.
  - Then a read miss goes to FETCH; a write miss goes to RESP.
- FETCH:
  - read_L2_MEM=1 with the latched tag/index, held until ready_MEM_L2.
  - On ready: install read_data_MEM_L2, valid=1, dirty=0, go to RESP.
- RESP:
  - Read: ready_L2_L1=1, read_data_L2_L1 = installed line.
  - Write miss: install write_data with valid=1, dirty=1, no memory fetch; ready_L2_L1=1.
  - Return to IDLE.
- Victim pointer: advances by 1 modulo NWAY only when a valid way is evicted.
- ready_MEM_L2 outside WB/FETCH: ignored.
- flush outside IDLE: ignored; L1 must re-issue.
- read_L2_MEM and write_L2_MEM are never high together.
- Requests are not re-sampled until the cycle after ready_L2_L1.

Optional Feature:
L2_DIRTY_FLUSH_EN
- Defined:
  - FLUSH walks sets 0..2**INUM-1 and ways 0..NWAY-1, one line per cycle.
  - Each valid+dirty line is written back using the WB handshake.
  - Every line is then invalidated and its victim pointer cleared.
  - flush_busy=1 from the cycle after the flush pulse until the final line; returns to IDLE afterwards.
- Undefined:
  - FLUSH clears all valid/dirty bits and pointers in one cycle, discarding dirty data.
  - flush_busy=1 for that single cycle.

Test Plan:
1. Cold read miss:
   - Stimulus: read tag=0x00001, idx=5; MEM returns 0xAA..AA.
   - Response: read_L2_MEM=1 with tag_L2_MEM=0x00001, index=5; after ready_MEM_L2, ready_L2_L1=1 with data 0xAA..AA.
2. Hit latency:
   - Stimulus: re-read tag=0x00001, idx=5.
   - Response: ready_L2_L1 two cycles after request; no MEM activity.
3. Fill and replace:
   - Stimulus: fill idx=5 with tags 1..NWAY, then read tag=0x3FFFF.
   - Response: evicts way 0 (pointer 0→1); next new tag evicts way 1.
4. Dirty write-back on miss:
   - Stimulus: write tag=2, idx=9, data 0x55..55; then read tag=3 with the set full.
   - Response: write_L2_MEM=1 with write_tag=2, write_index=9, data 0x55..55 before read_L2_MEM.
5. Write miss on a clean set:
   - Response: no read_L2_MEM.
   - A following read returns write_data with ready in 2 cycles.
6. Flush with dirty lines at idx 0 and 255:
   - Response with L2_DIRTY_FLUSH_EN: exactly two write-backs in index order, then all reads miss.
   - Response without it: zero write-backs.
   - Assert rst mid-WB: write_L2_MEM=0 the next cycle.
